motor_pwm_drive: RTL and testbench



---
 rtl/motor_pwm_drive.sv | 222 ++++++++++++++++++++++
 tb/tb_motor_pwm_drive.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/motor_pwm_drive.sv
// ---------------------------------------------------------------------------
// motor_pwm_drive
//
// Turns the PicoBlaze motor-control port bits into two PWM drive signals,
// one for the left motor driver and one for the right. Each channel has a
// soft-start duty ramp, an immediate hard stop and an at-speed status flag.
// Both channels share one prescaler, one PWM counter and the speed select.
//
// Build option:
//   MOTOR_PWM_RAMP_EN  defined   : duty moves toward the target by RAMP_STEP
//                                  once per PWM period.
//                      undefined : duty loads the target at the next period
//                                  start, so RAMP lasts at most one period.
//                                  RAMP_STEP is ignored.
//
// Parameters:
//   CLK_DIV    clk cycles per PWM counter tick (1..65535)
//   PWM_BITS   PWM counter / duty width; the period is 2**PWM_BITS ticks
//   DUTY_SLOW  target duty when slow0_fast1 = 0
//   DUTY_FAST  target duty when slow0_fast1 = 1
//   RAMP_STEP  duty change per PWM period while ramping
//
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   l_mtr_ctrl    in   left motor enable
//   r_mtr_ctrl    in   right motor enable
//   slow0_fast1   in   speed select shared by both channels
//   l_pwm         out  left motor PWM (registered)
//   r_pwm         out  right motor PWM (registered)
//   l_at_speed    out  left duty has reached its nonzero target
//   r_at_speed    out  right duty has reached its nonzero target
//   period_start  out  one-cycle pulse in the cycle the PWM counter is 0
// ---------------------------------------------------------------------------
module motor_pwm_drive #(
    parameter int CLK_DIV   = 100,
    parameter int PWM_BITS  = 8,
    parameter int DUTY_SLOW = 96,
    parameter int DUTY_FAST = 224,
    parameter int RAMP_STEP = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic l_mtr_ctrl,
    input  logic r_mtr_ctrl,
    input  logic slow0_fast1,
    output logic l_pwm,
    output logic r_pwm,
    output logic l_at_speed,
    output logic r_at_speed,
    output logic period_start
);

    localparam int W = PWM_BITS;

    localparam logic [15:0]  PRESC_MAX   = 16'(CLK_DIV - 1);
    localparam logic [W-1:0] DUTY_SLOW_V = W'(DUTY_SLOW);
    localparam logic [W-1:0] DUTY_FAST_V = W'(DUTY_FAST);

`ifdef MOTOR_PWM_RAMP_EN
    localparam logic [W-1:0] STEP_V = W'(RAMP_STEP);
`else
    // A full-scale step always clamps to the target, so the shared step
    // datapath below loads the target in a single update.
    localparam logic [W-1:0] STEP_V = W'(RAMP_STEP) | {W{1'b1}};
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        RUN  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input register: everything downstream uses these copies.
    // Bit 0 is the left channel, bit 1 the right channel.
    // ------------------------------------------------------------------
    logic [1:0] ctrl_q;
    logic       fast_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= 2'b00;
            fast_q <= 1'b0;
        end else begin
            ctrl_q <= {r_mtr_ctrl, l_mtr_ctrl};
            fast_q <= slow0_fast1;
        end
    end

    // ------------------------------------------------------------------
    // Prescaler and PWM counter
    // ------------------------------------------------------------------
    logic [15:0]  presc;
    logic [W-1:0] pwm_cnt;
    logic         tick;
    logic         wrap;

    assign tick = (presc == PRESC_MAX);
    // wrap marks the clock edge on which pwm_cnt goes from all-ones to 0.
    // Duty updates use this same edge, so a new duty is already in place
    // during the whole first tick of the period it governs.
    assign wrap = tick && (pwm_cnt == {W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc        <= 16'd0;
            pwm_cnt      <= '0;
            period_start <= 1'b0;
        end else begin
            presc        <= tick ? 16'd0 : presc + 16'd1;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
            period_start <= wrap;
        end
    end

    logic [W-1:0] speed_duty;
    assign speed_duty = fast_q ? DUTY_FAST_V : DUTY_SLOW_V;

    // ------------------------------------------------------------------
    // Per-channel duty FSM and output registers
    // ------------------------------------------------------------------
    logic [1:0] pwm_bits;
    logic [1:0] at_bits;

    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        state_t       state_reg;
        state_t       state_next;
        logic [W-1:0] duty_reg;
        logic [W-1:0] duty_next;
        logic [W-1:0] target;
        logic [W-1:0] stepped;
        logic [W:0]   up_sum;
        logic [W:0]   down_limit;
        logic         pwm_reg;
        logic         at_reg;

        assign target = ctrl_q[gi] ? speed_duty : '0;

        // One step toward the target, computed one bit wider so that
        // neither the add nor the down-limit can wrap; both sides clamp
        // at the target so the duty never overshoots.
        assign up_sum     = {1'b0, duty_reg} + {1'b0, STEP_V};
        assign down_limit = {1'b0, target} + {1'b0, STEP_V};

        always_comb begin
            stepped = duty_reg;
            if (duty_reg < target) begin
                stepped = (up_sum > {1'b0, target}) ? target : up_sum[W-1:0];
            end else if (duty_reg > target) begin
                stepped = ({1'b0, duty_reg} < down_limit) ? target
                                                          : duty_reg - STEP_V;
            end
        end

        always_comb begin
            state_next = state_reg;
            duty_next  = duty_reg;
            if (!ctrl_q[gi] || (target == '0)) begin
                // Hard stop: no wait for the period boundary.
                state_next = IDLE;
                duty_next  = '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        state_next = RAMP;
                        if (wrap) begin
                            duty_next = stepped;
                            if (stepped == target) begin
                                state_next = RUN;
                            end
                        end
                    end
                    RAMP: begin
                        if (wrap) begin
                            duty_next = stepped;
                            if (stepped == target) begin
                                state_next = RUN;
                            end
                        end
                    end
                    RUN: begin
                        // A speed toggle changes the target; ramp from the
                        // current duty rather than restarting from zero.
                        if (duty_reg != target) begin
                            state_next = RAMP;
                        end
                    end
                    default: begin
                        state_next = IDLE;
                        duty_next  = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_reg <= IDLE;
                duty_reg  <= '0;
                pwm_reg   <= 1'b0;
                at_reg    <= 1'b0;
            end else begin
                state_reg <= state_next;
                duty_reg  <= duty_next;
                pwm_reg   <= (pwm_cnt < duty_reg);
                at_reg    <= (state_reg == RUN);
            end
        end

        assign pwm_bits[gi] = pwm_reg;
        assign at_bits[gi]  = at_reg;
    end

    assign l_pwm      = pwm_bits[0];
    assign r_pwm      = pwm_bits[1];
    assign l_at_speed = at_bits[0];
    assign r_at_speed = at_bits[1];

endmodule

// File: tb/tb_motor_pwm_drive.sv
// ---------------------------------------------------------------------------
// tb_motor_pwm_drive
//
// Directed bench for motor_pwm_drive with CLK_DIV=2, PWM_BITS=4,
// DUTY_SLOW=6, DUTY_FAST=14, RAMP_STEP=4 (one PWM period = 32 clk cycles).
// Each table record is one PWM period: its inputs are applied in the cycle
// period_start is high, then l_pwm/r_pwm high cycles are counted over the
// next 32 cycles (2 x duty) and the at-speed flags are sampled at the next
// period_start. Expected values follow MOTOR_PWM_RAMP_EN.
// ---------------------------------------------------------------------------
module tb_motor_pwm_drive;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic l_mtr_ctrl = 1'b0;
    logic r_mtr_ctrl = 1'b0;
    logic slow0_fast1 = 1'b0;
    logic l_pwm;
    logic r_pwm;
    logic l_at_speed;
    logic r_at_speed;
    logic period_start;

    motor_pwm_drive #(
        .CLK_DIV  (2),
        .PWM_BITS (4),
        .DUTY_SLOW(6),
        .DUTY_FAST(14),
        .RAMP_STEP(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .l_mtr_ctrl  (l_mtr_ctrl),
        .r_mtr_ctrl  (r_mtr_ctrl),
        .slow0_fast1 (slow0_fast1),
        .l_pwm       (l_pwm),
        .r_pwm       (r_pwm),
        .l_at_speed  (l_at_speed),
        .r_at_speed  (r_at_speed),
        .period_start(period_start)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic l;
        logic r;
        logic f;
        int   l_high;
        int   r_high;
        logic l_at;
        logic r_at;
        logic same;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs[NVEC];

    task automatic check(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    task automatic set_vec(input int i, input logic l, input logic r, input logic f,
                           input int lh, input int rh,
                           input logic la, input logic ra, input logic sm);
        vecs[i].l      = l;
        vecs[i].r      = r;
        vecs[i].f      = f;
        vecs[i].l_high = lh;
        vecs[i].r_high = rh;
        vecs[i].l_at   = la;
        vecs[i].r_at   = ra;
        vecs[i].same   = sm;
    endtask

    // Wait (bounded) for the next negedge with period_start high.
    task automatic wait_ps(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_start && n < limit);
    endtask

    // Must be entered at a negedge where period_start is high.
    task automatic run_vec(input int i);
        int lh;
        int rh;
        int diff;
        int ps;
        l_mtr_ctrl  = vecs[i].l;
        r_mtr_ctrl  = vecs[i].r;
        slow0_fast1 = vecs[i].f;
        lh = 0;
        rh = 0;
        diff = 0;
        ps = 0;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            if (l_pwm === 1'b1) lh++;
            if (r_pwm === 1'b1) rh++;
            if (l_pwm !== r_pwm) diff++;
            if (period_start === 1'b1) ps++;
        end
        check($sformatf("v%0d_l_high", i), lh, vecs[i].l_high);
        check($sformatf("v%0d_r_high", i), rh, vecs[i].r_high);
        check($sformatf("v%0d_l_at_speed", i), int'(l_at_speed), int'(vecs[i].l_at));
        check($sformatf("v%0d_r_at_speed", i), int'(r_at_speed), int'(vecs[i].r_at));
        check($sformatf("v%0d_period_pulses", i), ps, 1);
        check($sformatf("v%0d_period_start_end", i), int'(period_start), 1);
        if (vecs[i].same) begin
            check($sformatf("v%0d_lr_differ_cycles", i), diff, 0);
        end
        $display("vec %0d l=%b r=%b fast=%b l_high=%0d r_high=%0d l_at=%b r_at=%b",
                 i, vecs[i].l, vecs[i].r, vecs[i].f, lh, rh, l_at_speed, r_at_speed);
    endtask

    initial begin
        int n;

        //          i   l  r  f  l_hi r_hi l_at r_at same
`ifdef MOTOR_PWM_RAMP_EN
        set_vec( 0, 1, 0, 1,  0,  0, 0, 0, 0);
        set_vec( 1, 1, 0, 1,  8,  0, 0, 0, 0);
        set_vec( 2, 1, 0, 1, 16,  0, 0, 0, 0);
        set_vec( 3, 1, 0, 1, 24,  0, 0, 0, 0);
        set_vec( 4, 1, 0, 1, 28,  0, 1, 0, 0);
        set_vec( 5, 1, 0, 1, 28,  0, 1, 0, 0);
        set_vec( 6, 1, 0, 1,  0,  0, 0, 0, 0);
        set_vec( 7, 1, 0, 1,  8,  0, 0, 0, 0);
        set_vec( 8, 1, 0, 1, 16,  0, 0, 0, 0);
        set_vec( 9, 1, 0, 1, 24,  0, 0, 0, 0);
        set_vec(10, 1, 0, 1, 28,  0, 1, 0, 0);
        set_vec(11, 1, 0, 0, 28,  0, 0, 0, 0);
        set_vec(12, 1, 0, 0, 20,  0, 0, 0, 0);
        set_vec(13, 1, 0, 0, 12,  0, 1, 0, 0);
        set_vec(14, 0, 0, 0,  2,  0, 0, 0, 0);
        set_vec(15, 1, 1, 0,  0,  0, 0, 0, 1);
        set_vec(16, 1, 1, 0,  8,  8, 0, 0, 1);
        set_vec(17, 1, 1, 0, 12, 12, 1, 1, 1);
        set_vec(18, 1, 1, 0, 12, 12, 1, 1, 1);
        set_vec(19, 1, 1, 0,  8,  8, 0, 0, 1);
        set_vec(20, 1, 1, 0, 12, 12, 1, 1, 1);
`else
        set_vec( 0, 1, 0, 1,  0,  0, 0, 0, 0);
        set_vec( 1, 1, 0, 1, 28,  0, 1, 0, 0);
        set_vec( 2, 1, 0, 1, 28,  0, 1, 0, 0);
        set_vec( 3, 1, 0, 1, 28,  0, 1, 0, 0);
        set_vec( 4, 1, 0, 1, 28,  0, 1, 0, 0);
        set_vec( 5, 1, 0, 1, 28,  0, 1, 0, 0);
        set_vec( 6, 1, 0, 1,  0,  0, 0, 0, 0);
        set_vec( 7, 1, 0, 1, 28,  0, 1, 0, 0);
        set_vec( 8, 1, 0, 1, 28,  0, 1, 0, 0);
        set_vec( 9, 1, 0, 1, 28,  0, 1, 0, 0);
        set_vec(10, 1, 0, 1, 28,  0, 1, 0, 0);
        set_vec(11, 1, 0, 0, 28,  0, 0, 0, 0);
        set_vec(12, 1, 0, 0, 12,  0, 1, 0, 0);
        set_vec(13, 1, 0, 0, 12,  0, 1, 0, 0);
        set_vec(14, 0, 0, 0,  2,  0, 0, 0, 0);
        set_vec(15, 1, 1, 0,  0,  0, 0, 0, 1);
        set_vec(16, 1, 1, 0, 12, 12, 1, 1, 1);
        set_vec(17, 1, 1, 0, 12, 12, 1, 1, 1);
        set_vec(18, 1, 1, 0, 12, 12, 1, 1, 1);
        set_vec(19, 1, 1, 0, 12, 12, 1, 1, 1);
        set_vec(20, 1, 1, 0, 12, 12, 1, 1, 1);
`endif

        // Reset values, then distance from release to first period_start.
        repeat (3) @(negedge clk);
        check("reset_l_pwm", int'(l_pwm), 0);
        check("reset_r_pwm", int'(r_pwm), 0);
        check("reset_l_at_speed", int'(l_at_speed), 0);
        check("reset_r_at_speed", int'(r_at_speed), 0);
        check("reset_period_start", int'(period_start), 0);
        rst_n = 1'b1;
        wait_ps(100, n);
        check("first_period_start_cycles", n, 32);
        $display("reset released, first period_start after %0d cycles", n);

        // Fast start on the left channel.
        for (int i = 0; i <= 5; i++) run_vec(i);

        // Hard stop in the middle of a period with duty 14.
        repeat (5) @(negedge clk);
        check("stop_pwm_before", int'(l_pwm), 1);
        l_mtr_ctrl = 1'b0;
        repeat (2) @(negedge clk);
        check("stop_pwm_after2", int'(l_pwm), 1);
        @(negedge clk);
        check("stop_pwm_after3", int'(l_pwm), 0);
        check("stop_at_speed_after3", int'(l_at_speed), 0);
        wait_ps(64, n);
        check("stop_realign_cycles", n, 24);
        $display("hard stop mid-period, realigned after %0d cycles", n);

        // Restart, fast->slow, stop at period boundary, both channels slow.
        for (int i = 6; i <= 18; i++) run_vec(i);

        // Asynchronous reset while both channels run.
        @(negedge clk);
        check("midrun_l_pwm_before", int'(l_pwm), 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_reset_l_pwm", int'(l_pwm), 0);
        check("midrun_reset_r_pwm", int'(r_pwm), 0);
        check("midrun_reset_l_at_speed", int'(l_at_speed), 0);
        check("midrun_reset_r_at_speed", int'(r_at_speed), 0);
        check("midrun_reset_period_start", int'(period_start), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ps(100, n);
        check("midrun_first_period_start_cycles", n, 32);
        $display("mid-run reset released, first period_start after %0d cycles", n);

        for (int i = 19; i < NVEC; i++) run_vec(i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
